// File: rtl/rf_wb_sequencer.sv
// Register-file write sequencer: buffers writeback requests in a small FIFO and
// issues each one as a single-cycle write command, with a pending-write scoreboard.
module rf_wb_sequencer #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_kind,
   input  logic [3:0]    req_wr,
   input  logic [3:0]    req_wr2,
   input  logic [15:0]   req_wd,
   input  logic [15:0]   req_wd2,
   input  logic [15:0]   req_wd15,
   input  logic          stall,
   output logic [2:0]    regWrite,
   output logic [3:0]    wr,
   output logic [3:0]    wr2,
   output logic [15:0]   wd,
   output logic [15:0]   wd2,
   output logic [15:0]   wd15,
   input  logic [3:0]    rr1,
   input  logic [3:0]    rr2,
   output logic          hazard1,
   output logic          hazard2,
   output logic [CW-1:0] count,
   output logic          busy
);

   localparam int PW = CW - 1;

   typedef struct packed {
      logic [1:0]  kind;
      logic [3:0]  wr;
      logic [3:0]  wr2;
      logic [15:0] wd;
      logic [15:0] wd2;
      logic [15:0] wd15;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count_q;
   logic            full;
   logic            push;
   logic            pop;
   entry_t          head;

   // Command encoding after collision collapse: a dual write to one register
   // keeps only the wr2 side, and a flag write whose primary is r15 keeps wd.
   function automatic logic [2:0] collapse(input logic [1:0] kind,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
      logic [2:0] c;
      case (kind)
         2'b00:   c = 3'b001;
         2'b01:   c = 3'b010;
         2'b10:   c = (a == b) ? 3'b010 : 3'b011;
         default: c = (a == 4'd15) ? 3'b001 : 3'b101;
      endcase
      return c;
   endfunction

   function automatic logic targets(input logic [2:0] cmd,
                                    input logic [3:0] a,
                                    input logic [3:0] b,
                                    input logic [3:0] r);
      logic t;
      case (cmd)
         3'b001:  t = (r == a);
         3'b010:  t = (r == b);
         3'b011:  t = (r == a) || (r == b);
         3'b101:  t = (r == a) || (r == 4'd15);
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   // Request handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both high; req_ready depends only on occupancy, never on req_valid.
   assign full      = (count_q == CW'(DEPTH));
   assign req_ready = !full;
   assign push      = req_valid && !full;
   assign pop       = (count_q != '0) && !stall;
   assign head      = mem[rd_ptr];
   assign count     = count_q;
   assign busy      = (count_q != '0) || (regWrite != 3'b000);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{kind: req_kind, wr: req_wr, wr2: req_wr2,
                             wd: req_wd, wd2: req_wd2, wd15: req_wd15};
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Issued command lasts one cycle; data fields hold their last values when idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regWrite <= 3'b000;
         wr       <= '0;
         wr2      <= '0;
         wd       <= '0;
         wd2      <= '0;
         wd15     <= '0;
      end else if (pop) begin
         regWrite <= collapse(head.kind, head.wr, head.wr2);
         wr       <= head.wr;
         wr2      <= head.wr2;
         wd       <= head.wd;
         wd2      <= head.wd2;
         wd15     <= head.wd15;
      end else begin
         regWrite <= 3'b000;
      end
   end

   always_comb begin
      logic [PW-1:0] offset;
      hazard1 = targets(regWrite, wr, wr2, rr1);
      hazard2 = targets(regWrite, wr, wr2, rr2);
      offset  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset = PW'(i) - rd_ptr;
         if ({1'b0, offset} < count_q) begin
            if (targets(collapse(mem[i].kind, mem[i].wr, mem[i].wr2),
                        mem[i].wr, mem[i].wr2, rr1)) hazard1 = 1'b1;
            if (targets(collapse(mem[i].kind, mem[i].wr, mem[i].wr2),
                        mem[i].wr, mem[i].wr2, rr2)) hazard2 = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_sequencer.sv
// Bench for rf_wb_sequencer: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the request stream.
module tb_rf_wb_sequencer;

   localparam int DEPTH = 4;
   localparam int CW    = 3;
   localparam int W     = 58;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_kind;
   logic [3:0]    req_wr;
   logic [3:0]    req_wr2;
   logic [15:0]   req_wd;
   logic [15:0]   req_wd2;
   logic [15:0]   req_wd15;
   logic          stall;
   logic [2:0]    regWrite;
   logic [3:0]    wr;
   logic [3:0]    wr2;
   logic [15:0]   wd;
   logic [15:0]   wd2;
   logic [15:0]   wd15;
   logic [3:0]    rr1;
   logic [3:0]    rr2;
   logic          hazard1;
   logic          hazard2;
   logic [CW-1:0] count;
   logic          busy;

   rf_wb_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
      .req_wr(req_wr), .req_wr2(req_wr2), .req_wd(req_wd), .req_wd2(req_wd2),
      .req_wd15(req_wd15), .stall(stall),
      .regWrite(regWrite), .wr(wr), .wr2(wr2), .wd(wd), .wd2(wd2), .wd15(wd15),
      .rr1(rr1), .rr2(rr2), .hazard1(hazard1), .hazard2(hazard2),
      .count(count), .busy(busy)
   );

   // clock / reset
   always #5 clk = ~clk;

   // scoreboard: queued requests packed as {kind, wr, wr2, wd, wd2, wd15}
   logic [W-1:0] exp_q[$];
   logic [2:0]   exp_cmd;
   logic [3:0]   exp_wr, exp_wr2;
   logic [15:0]  exp_wd, exp_wd2, exp_wd15;
   int           checks = 0;
   int           errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Command a request turns into, straight from the kind/collision rules.
   function automatic logic [2:0] cmd_of(input logic [W-1:0] e);
      logic [1:0] k;
      logic [3:0] a, b;
      k = e[57:56];
      a = e[55:52];
      b = e[51:48];
      if (k == 2'b00) return 3'b001;
      if (k == 2'b01) return 3'b010;
      if (k == 2'b10) return (a == b) ? 3'b010 : 3'b011;
      return (a == 4'd15) ? 3'b001 : 3'b101;
   endfunction

   function automatic bit writes_reg(input logic [2:0] cmd, input logic [3:0] a,
                                     input logic [3:0] b, input logic [3:0] r);
      case (cmd)
         3'b001:  return r == a;
         3'b010:  return r == b;
         3'b011:  return (r == a) || (r == b);
         3'b101:  return (r == a) || (r == 4'd15);
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit model_hazard(input logic [3:0] r);
      bit h;
      h = writes_reg(exp_cmd, exp_wr, exp_wr2, r);
      foreach (exp_q[i]) if (writes_reg(cmd_of(exp_q[i]), exp_q[i][55:52], exp_q[i][51:48], r)) h = 1'b1;
      return h;
   endfunction

   task automatic model_clear();
      exp_q.delete();
      exp_cmd = 3'b000;
      exp_wr = '0; exp_wr2 = '0; exp_wd = '0; exp_wd2 = '0; exp_wd15 = '0;
   endtask

   task automatic check_outputs();
      check("count", 32'(count), 32'(exp_q.size()));
      check("req_ready", 32'(req_ready), 32'(exp_q.size() < DEPTH));
      check("regWrite", 32'(regWrite), 32'(exp_cmd));
      check("wr", 32'(wr), 32'(exp_wr));
      check("wr2", 32'(wr2), 32'(exp_wr2));
      check("wd", 32'(wd), 32'(exp_wd));
      check("wd2", 32'(wd2), 32'(exp_wd2));
      check("wd15", 32'(wd15), 32'(exp_wd15));
      check("hazard1", 32'(hazard1), 32'(model_hazard(rr1)));
      check("hazard2", 32'(hazard2), 32'(model_hazard(rr2)));
      check("busy", 32'(busy), 32'((exp_q.size() != 0) || (exp_cmd != 3'b000)));
   endtask

   // driver: one clock cycle with the given inputs, checked then modelled
   task automatic cycle(input logic v, input logic [1:0] k, input logic [3:0] a,
                        input logic [3:0] b, input logic [15:0] d, input logic [15:0] d2,
                        input logic [15:0] d15, input logic s, input logic [3:0] r1,
                        input logic [3:0] r2);
      logic [W-1:0] e;
      int sz;
      @(negedge clk);
      req_valid = v; req_kind = k; req_wr = a; req_wr2 = b;
      req_wd = d; req_wd2 = d2; req_wd15 = d15; stall = s; rr1 = r1; rr2 = r2;
      #1 check_outputs();
      @(posedge clk);
      sz = exp_q.size();
      if (sz != 0 && !s) begin
         e = exp_q.pop_front();
         exp_cmd = cmd_of(e);
         exp_wr = e[55:52]; exp_wr2 = e[51:48];
         exp_wd = e[47:32]; exp_wd2 = e[31:16]; exp_wd15 = e[15:0];
      end else begin
         exp_cmd = 3'b000;
      end
      if (v && sz < DEPTH) exp_q.push_back({k, a, b, d, d2, d15});
   endtask

   task automatic idle(input int n, input logic s);
      for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, s, 4'd0, 4'd0);
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 1'b0; req_kind = '0; req_wr = '0; req_wr2 = '0;
      req_wd = '0; req_wd2 = '0; req_wd15 = '0; stall = 1'b0; rr1 = '0; rr2 = '0;
      model_clear();
      #1;
      check("rst_regWrite", 32'(regWrite), 32'h0);
      check("rst_count", 32'(count), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // single kind 00 write
      cycle(1'b1, 2'b00, 4'd3, 4'd0, 16'h1234, 16'h0, 16'h0, 1'b0, 4'd3, 4'd0);
      idle(3, 1'b0);

      // five requests under stall, then drain with the fifth held on the port
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 2'(i % 4), 4'(i), 4'(i + 8), 16'(i * 16'h111), 16'(~i), 16'(i + 16'h100), 1'b1, 4'(i), 4'd8);
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 2'b00, 4'd4, 4'd12, 16'h0444, 16'h0, 16'h0, 1'b0, 4'd4, 4'd2);
      idle(3, 1'b0);

      // collisions
      cycle(1'b1, 2'b10, 4'd7, 4'd7, 16'hAAAA, 16'h5555, 16'h0, 1'b0, 4'd7, 4'd0);
      cycle(1'b1, 2'b11, 4'd15, 4'd0, 16'h0001, 16'h0, 16'hFFFF, 1'b0, 4'd15, 4'd7);
      idle(3, 1'b0);

      // flag write hazards on r15 and r2, none on r4
      cycle(1'b1, 2'b11, 4'd2, 4'd0, 16'h0022, 16'h0, 16'h8000, 1'b1, 4'd15, 4'd2);
      idle(2, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 4'd15, 4'd2);
      for (int i = 0; i < 2; i++) cycle(1'b0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 4'd4, 4'd2);

      // full FIFO: pop with refused push, then push while issuing
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 2'b01, 4'(i), 4'(i + 4), 16'h0, 16'(16'hB000 + i), 16'h0, 1'b1, 4'd5, 4'd0);
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 2'b00, 4'(10 + i), 4'd0, 16'(16'hC000 + i), 16'h0, 16'h0, 1'b0, 4'd10, 4'd6);
      idle(6, 1'b0);

      // asynchronous reset with three queued and one dual write in flight
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 2'b10, 4'(i + 1), 4'(i + 9), 16'(16'hD000 + i), 16'(16'hE000 + i), 16'h0, 1'b1, 4'd1, 4'd9);
      cycle(1'b0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 4'd1, 4'd9);
      @(negedge clk);
      #1;
      check("pre_rst_count", 32'(count), 32'h3);
      check("pre_rst_regWrite", 32'(regWrite), 32'h3);
      check("pre_rst_hazard1", 32'(hazard1), 32'h1);
      reset = 1'b1;
      #1;
      check("mid_rst_regWrite", 32'(regWrite), 32'h0);
      check("mid_rst_count", 32'(count), 32'h0);
      check("mid_rst_hazard1", 32'(hazard1), 32'h0);
      check("mid_rst_hazard2", 32'(hazard2), 32'h0);
      check("mid_rst_ready", 32'(req_ready), 32'h1);
      model_clear();
      #1 reset = 1'b0;
      cycle(1'b1, 2'b10, 4'd5, 4'd6, 16'h5A5A, 16'h6B6B, 16'h0, 1'b0, 4'd5, 4'd6);
      idle(3, 1'b0);

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         logic [3:0] a, b;
         logic [1:0] k;
         k = 2'($urandom_range(0, 3));
         a = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
         b = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
         cycle($urandom_range(0, 99) < 60, k, a, b, 16'($urandom), 16'($urandom), 16'($urandom),
               $urandom_range(0, 99) < 30, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      idle(8, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
